// File: rtl/ysyx_22051013_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// the NOP substituted on misaligned fetches, FSM state encoding and the
// doubleword-to-instruction select helper.
package ysyx_22051013_ifu_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0]   YSYX_22051013_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] YSYX_22051013_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Memory returns an aligned doubleword; pc[2] picks the upper or lower word.
  function automatic logic [INST_W-1:0] sel_word(input logic [PC_W-1:0] pc,
                                                 input logic [63:0]     dword);
    return pc[2] ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22051013_ifu_pcgen.sv
// PC register, next-PC selection (redirect / pc+4 / hold) and the kill flag
// that marks an in-flight fetch as stale.
// Ports: clk, rst; state and handshake events from the fetch FSM; redirect
// request; outputs pc, pc_next (for registered request-valid) and kill.
module ysyx_22051013_ifu_pcgen
  import ysyx_22051013_ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = YSYX_22051013_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  state_t          state,
  input  logic            req_fire,
  input  logic            resp_valid,
  input  logic            out_fire,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            kill
);

  logic kill_next;

  // Redirect beats every other PC update.
  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = redirect_pc;
    else if (out_fire)
      pc_next = pc + 64'd4;
  end

  // kill tracks a single outstanding response that must be dropped. Any
  // response arriving in WAIT retires it, including one coincident with a
  // redirect (that response is dropped by the FSM directly).
  always_comb begin
    kill_next = kill;
    case (state)
      ST_REQ: begin
        if (redirect_valid && req_fire)
          kill_next = 1'b1;
      end
      ST_WAIT: begin
        if (resp_valid)
          kill_next = 1'b0;
        else if (redirect_valid)
          kill_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_PC;
      kill <= 1'b0;
    end else begin
      pc   <= pc_next;
      kill <= kill_next;
    end
  end

endmodule

// File: rtl/ysyx_22051013_ifu.sv
// Instruction fetch stage: owns the PC, issues one aligned doubleword read per
// instruction, selects the 32-bit word and hands {pc, inst} to decode.
// Ports: clk/rst; redirect_valid/redirect_pc from execute; imem_req_* request
// channel (valid/ready); imem_resp_* read data; inst_valid_o/inst_ready_i,
// inst_o, pc_o, misalign_o toward decode.
module ysyx_22051013_ifu
  import ysyx_22051013_ifu_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = YSYX_22051013_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = YSYX_22051013_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [63:0]       imem_resp_data,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              misalign_o
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic            kill;
  logic            req_fire, resp_fire, out_fire, misaligned;
  logic            load_fetch, load_nop;

  assign req_fire      = imem_req_valid & imem_req_ready;
  assign resp_fire     = (state == ST_WAIT) & imem_resp_valid;
  assign out_fire      = inst_valid_o & inst_ready_i;
  assign misaligned    = (pc[1:0] != 2'b00);
  assign imem_req_addr = {pc[PC_W-1:3], 3'b000};

  ysyx_22051013_ifu_pcgen #(
    .RESET_PC (RESET_PC)
  ) u_pcgen (
    .clk            (clk),
    .rst            (rst),
    .state          (state),
    .req_fire       (req_fire),
    .resp_valid     (resp_fire),
    .out_fire       (out_fire),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .pc_next        (pc_next),
    .kill           (kill)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        // An accepted request targets the old pc even under redirect; kill
        // covers that case. A redirect without acceptance just retries.
        if (req_fire)
          state_next = ST_WAIT;
        else if (redirect_valid)
          state_next = ST_REQ;
        else if (misaligned)
          state_next = ST_OUT;
      end
      ST_WAIT: begin
        if (imem_resp_valid)
          state_next = (kill || redirect_valid) ? ST_REQ : ST_OUT;
      end
      ST_OUT: begin
        if (redirect_valid || inst_ready_i)
          state_next = ST_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output-load decisions.
  always_comb begin
    load_fetch = (state == ST_WAIT) && imem_resp_valid && !kill && !redirect_valid;
    load_nop   = (state == ST_REQ) && misaligned && !redirect_valid;
  end

  // Registered outputs. Request valid is precomputed from next state/pc so
  // a misaligned pc never raises it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req_valid <= 1'b0;
      inst_valid_o   <= 1'b0;
      inst_o         <= '0;
      pc_o           <= '0;
      misalign_o     <= 1'b0;
    end else begin
      imem_req_valid <= (state_next == ST_REQ) && (pc_next[1:0] == 2'b00);
      inst_valid_o   <= (state_next == ST_OUT);
      if (load_fetch) begin
        inst_o     <= sel_word(pc, imem_resp_data);
        pc_o       <= pc;
        misalign_o <= 1'b0;
      end else if (load_nop) begin
        inst_o     <= NOP_INST;
        pc_o       <= pc;
        misalign_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_ifu.sv
`timescale 1ns/1ps
module tb_ysyx_22051013_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        misalign_o;

  // Memory model and stale-response injector drive separate sources.
  logic        mem_rv = 1'b0, inj_rv = 1'b0;
  logic [63:0] mem_rd = '0, inj_rd = '0;
  assign imem_resp_valid = mem_rv | inj_rv;
  assign imem_resp_data  = inj_rv ? inj_rd : mem_rd;

  int total = 0;
  int bad   = 0;
  int fires = 0;
  bit mem_auto = 1'b1;
  int resp_lat = 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] req_q[$];

  always #5 clk = ~clk;

  ysyx_22051013_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .misalign_o      (misalign_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic [63:0] memword(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000)
      return 64'hAAAA_BBBB_0000_0013;
    return {~a[31:0], a[31:0]};
  endfunction

  // Memory: one response per accepted request, resp_lat cycles after acceptance.
  initial begin : mem_model
    logic [63:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (mem_auto && !rst && imem_req_valid && imem_req_ready) begin
        a   = imem_req_addr;
        lat = resp_lat;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        mem_rd = memword(a);
        mem_rv = 1'b1;
        @(posedge clk);
        #1;
        mem_rv = 1'b0;
      end
    end
  end

  // Monitor: request addresses, delivered instructions, hold stability.
  initial begin : monitor
    exp_t e;
    exp_t held;
    bit   hold_v;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        fires++;
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got addr %h want no request", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, req_q.pop_front());
        end
      end
      if (!rst && inst_valid_o && inst_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got pc %h inst %h want nothing", pc_o, inst_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", pc_o, e.pc);
          chk("out_inst", {32'h0, inst_o}, {32'h0, e.inst});
          chk("out_mis", {63'h0, misalign_o}, {63'h0, e.mis});
        end
      end
      if (!rst && hold_v) begin
        chk("hold_valid", {63'h0, inst_valid_o}, 64'h1);
        chk("hold_pc", pc_o, held.pc);
        chk("hold_inst", {32'h0, inst_o}, {32'h0, held.inst});
      end
      hold_v = !rst && inst_valid_o && !inst_ready_i && !redirect_valid;
      held   = '{pc: pc_o, inst: inst_o, mis: misalign_o};
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!inst_valid_o && waited < 50) begin
      tick();
      waited++;
    end
    if (!inst_valid_o) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got no inst_valid_o want inst_valid_o");
    end
  endtask

  // Expect one delivery; optionally redirect on the handshake cycle.
  task automatic deliver(input logic [63:0] p, input logic [31:0] i, input logic m,
                         input bit rd, input logic [63:0] rpc, output int waited);
    exp_q.push_back('{pc: p, inst: i, mis: m});
    inst_ready_i = 1'b1;
    wait_valid(waited);
    if (inst_valid_o) begin
      if (rd) begin
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
      tick();
      redirect_valid = 1'b0;
    end
    inst_ready_i = 1'b0;
  endtask

  initial begin : stimulus
    int w;
    int f0;

    // Reset state.
    repeat (2) tick();
    chk("rst_inst_valid", {63'h0, inst_valid_o}, 64'h0);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_pc_o", pc_o, 64'h0);
    chk("rst_inst_o", {32'h0, inst_o}, 64'h0);
    chk("rst_misalign", {63'h0, misalign_o}, 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h8000_0000);

    // First fetches, zero-wait memory.
    req_q.push_back(64'h8000_0000);
    req_q.push_back(64'h8000_0000);
    req_q.push_back(64'h8000_0008);
    rst = 1'b0;
    deliver(64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 64'h0, w);
    chk("first_latency", 64'(w), 64'd3);
    deliver(64'h8000_0004, 32'hAAAA_BBBB, 1'b0, 1'b0, 64'h0, w);

    // Decode stalls for 5 cycles in OUT.
    wait_valid(w);
    f0 = fires;
    repeat (5) tick();
    chk("stall_no_req", 64'(fires), 64'(f0));
    deliver(64'h8000_0008, 32'h8000_0008, 1'b0, 1'b0, 64'h0, w);

    // Redirect in WAIT, stale response 3 cycles later.
    req_q.push_back(64'h8000_0008);
    req_q.push_back(64'h8000_0100);
    resp_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    resp_lat = 1;
    deliver(64'h8000_0100, 32'h8000_0100, 1'b0, 1'b0, 64'h0, w);
    chk("kill_latency", 64'(w), 64'd4);

    // Redirect coincident with response, then with OUT handshake.
    req_q.push_back(64'h8000_0100);
    req_q.push_back(64'h8000_0200);
    req_q.push_back(64'h8000_0300);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    deliver(64'h8000_0200, 32'h8000_0200, 1'b0, 1'b1, 64'h8000_0300, w);
    chk("coinc_latency", 64'(w), 64'd2);
    deliver(64'h8000_0300, 32'h8000_0300, 1'b0, 1'b1, 64'h8000_0102, w);

    // Misaligned pc: NOP without a memory request.
    f0 = fires;
    deliver(64'h8000_0102, 32'h0000_0013, 1'b1, 1'b0, 64'h0, w);
    chk("mis_latency", 64'(w), 64'd1);
    wait_valid(w);
    chk("mis_next_pc", pc_o, 64'h8000_0106);
    chk("mis_next_flag", {63'h0, misalign_o}, 64'h1);
    chk("mis_no_req", 64'(fires), 64'(f0));

    // Redirect while OUT is stalled drops the held instruction.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    chk("drop_valid", {63'h0, inst_valid_o}, 64'h0);
    req_q.push_back(64'h8000_0010);
    deliver(64'h8000_0010, 32'h8000_0010, 1'b0, 1'b0, 64'h0, w);

    // Reset in WAIT, stale response after release.
    req_q.push_back(64'h8000_0010);
    mem_auto = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_inst_valid", {63'h0, inst_valid_o}, 64'h0);
    chk("arst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("arst_pc_o", pc_o, 64'h0);
    chk("arst_req_addr", imem_req_addr, 64'h8000_0000);
    tick();
    rst      = 1'b0;
    inj_rv   = 1'b1;
    inj_rd   = 64'hDEAD_BEEF_DEAD_BEEF;
    mem_auto = 1'b1;
    req_q.push_back(64'h8000_0000);
    tick();
    inj_rv = 1'b0;
    deliver(64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 64'h0, w);
    chk("restart_latency", 64'(w), 64'd2);
    imem_req_ready = 1'b0;

    repeat (3) tick();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
